// File: rtl/note_sequencer.sv
// note_sequencer: parametrised guitar-note recorder/player.
// Samples string/fret inputs once per beat into an internal note memory and
// plays them back at the same tempo, with a runtime tempo period, optional
// loop playback, auto-stop when the memory fills, and length tracking.
//
// Ports:
//   clk, resetn             clock; synchronous active-low reset
//   period                  clocks per beat (values below 2 behave as 2)
//   rec_start/play_start    1-cycle command pulses, honoured in IDLE only
//   stop                    1-cycle pulse, returns to IDLE from any state
//   loop_en                 playback wraps to entry 0 when set at the wrap point
//   strings, frets          level inputs from the debounce layer
//   note_out, note_valid    played note word and its 1-cycle strobe
//   beat                    1-cycle beat strobe while recording or playing
//   state                   0=IDLE 1=REC 2=PLAY
//   length, full            notes stored, and length==DEPTH
module note_sequencer #(
  parameter int N_STRINGS = 6,
  parameter int N_FRETS   = 4,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int CNT_W     = 27,
  parameter int NOTE_W    = N_STRINGS * (N_FRETS + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [CNT_W-1:0]     period,
  input  logic                 rec_start,
  input  logic                 play_start,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic [N_STRINGS-1:0] strings,
  input  logic [N_FRETS-1:0]   frets,
  output logic [NOTE_W-1:0]    note_out,
  output logic                 note_valid,
  output logic                 beat,
  output logic [1:0]           state,
  output logic [ADDR_W:0]      length,
  output logic                 full
);

  localparam int FI_W = $clog2(N_FRETS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t               st;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     reload;
  logic                 tick;
  logic [N_STRINGS-1:0] acc_s;
  logic [N_FRETS-1:0]   acc_f;
  logic [N_STRINGS-1:0] s_now;
  logic [N_FRETS-1:0]   f_now;
  logic [FI_W-1:0]      fret_idx;
  logic [NOTE_W-1:0]    word;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 last_entry;
  logic                 play_last;
  logic                 wr_en;
  logic [NOTE_W-1:0]    mem [DEPTH];

  // Accumulator view including the current cycle's inputs, so the beat cycle
  // itself contributes to the stored word.
  assign s_now = acc_s | strings;
  assign f_now = acc_f | frets;

  always_comb begin
    fret_idx = '0;
    for (int unsigned i = 0; i < N_FRETS; i++)
      if (f_now[i]) fret_idx = FI_W'(i + 1);
  end

  always_comb begin
    word = '0;
    for (int unsigned f = 0; f < N_FRETS + 1; f++)
      if (fret_idx == FI_W'(f)) word[f*N_STRINGS +: N_STRINGS] = s_now;
  end

  always_comb begin
    reload = ((period < CNT_W'(2)) ? CNT_W'(2) : period) - CNT_W'(1);
  end

  assign tick       = (st != S_IDLE) && (cnt == '0);
  assign beat       = tick;
  assign state      = st;
  assign last_entry = ({1'b0, rd_addr} == (length - 1'b1));
  assign wr_en      = resetn && (st == S_REC) && tick && !stop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= word;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st         <= S_IDLE;
      cnt        <= '0;
      acc_s      <= '0;
      acc_f      <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      length     <= '0;
      full       <= 1'b0;
      note_out   <= '0;
      note_valid <= 1'b0;
      play_last  <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (stop) begin
            st <= S_IDLE;
          end else if (rec_start) begin
            st      <= S_REC;
            length  <= '0;
            full    <= 1'b0;
            wr_addr <= '0;
            acc_s   <= '0;
            acc_f   <= '0;
            cnt     <= reload;
          end else if (play_start && (length != '0)) begin
            st        <= S_PLAY;
            rd_addr   <= '0;
            cnt       <= reload;
            play_last <= 1'b0;
          end
        end
        S_REC: begin
          if (stop) begin
            st    <= S_IDLE;
            acc_s <= '0;
            acc_f <= '0;
          end else if (tick) begin
            cnt     <= reload;
            wr_addr <= wr_addr + 1'b1;
            length  <= length + 1'b1;
            acc_s   <= '0;
            acc_f   <= '0;
            if (length == (ADDR_W+1)'(DEPTH - 1)) begin
              full <= 1'b1;
              st   <= S_IDLE;
            end
          end else begin
            cnt   <= cnt - 1'b1;
            acc_s <= s_now;
            acc_f <= f_now;
          end
        end
        S_PLAY: begin
          if (stop) begin
            st <= S_IDLE;
          end else begin
            cnt <= tick ? reload : cnt - 1'b1;
            // Leave PLAY one cycle after the final beat so the last
            // note_valid is still seen inside PLAY.
            if (play_last) begin
              st        <= S_IDLE;
              play_last <= 1'b0;
            end
            if (tick) begin
              note_out   <= mem[rd_addr];
              note_valid <= 1'b1;
              if (last_entry) begin
                if (loop_en) rd_addr <= '0;
                else         play_last <= 1'b1;
              end else begin
                rd_addr <= rd_addr + 1'b1;
              end
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  localparam int NS = 6;
  localparam int NF = 4;
  localparam int DP = 4;
  localparam int AW = 2;
  localparam int CW = 8;
  localparam int NW = NS * (NF + 1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [CW-1:0] period = 8'd4;
  logic          rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [NS-1:0] strings = '0;
  logic [NF-1:0] frets = '0;
  logic [NW-1:0] note_out;
  logic          note_valid, beat, full;
  logic [1:0]    state;
  logic [AW:0]   length;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  note_sequencer #(.N_STRINGS(NS), .N_FRETS(NF), .DEPTH(DP), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .period(period), .rec_start(rec_start),
    .play_start(play_start), .stop(stop), .loop_en(loop_en), .strings(strings),
    .frets(frets), .note_out(note_out), .note_valid(note_valid), .beat(beat),
    .state(state), .length(length), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Beats are located by elapsed time since entry (age mod period), the
  // stored word is the OR of strings shifted by the highest fret seen.
  int          m_state = 0, m_len = 0, m_idx = 0, m_age = 0, m_P = 2, m_acc_f = 0;
  bit          m_full = 0, m_valid = 0, m_last = 0;
  logic [NS-1:0] m_acc_s = '0;
  logic [NW-1:0] m_note = '0;
  logic [NW-1:0] m_mem [DP];

  function automatic int eff(input logic [CW-1:0] p);
    return (p < 2) ? 2 : int'(p);
  endfunction

  function automatic int top_fret(input logic [NF-1:0] f);
    int hi = 0;
    for (int i = 0; i < NF; i++) if (f[i]) hi = i + 1;
    return hi;
  endfunction

  function automatic bit model_beat();
    return (m_state != 0) && ((m_age % m_P) == m_P - 1);
  endfunction

  initial begin
    forever begin
      bit b;
      int hi;
      @(negedge clk);
      b = model_beat();
      if (chk_en) begin
        chk("state", 32'(state), 32'(m_state));
        chk("length", 32'(length), 32'(m_len));
        chk("full", 32'(full), 32'(m_full));
        chk("beat", 32'(beat), 32'(b));
        chk("note_valid", 32'(note_valid), 32'(m_valid));
        chk("note_out", 32'(note_out), 32'(m_note));
      end
      // advance with the inputs the coming posedge will sample
      m_valid = 0;
      if (!resetn) begin
        m_state = 0; m_len = 0; m_full = 0; m_note = '0; m_age = 0;
        m_P = 2; m_last = 0; m_acc_s = '0; m_acc_f = 0;
      end else begin
        case (m_state)
          0: begin
            if (stop) begin
            end else if (rec_start) begin
              m_state = 1; m_len = 0; m_full = 0; m_idx = 0;
              m_acc_s = '0; m_acc_f = 0; m_age = 0; m_P = eff(period);
            end else if (play_start && m_len != 0) begin
              m_state = 2; m_idx = 0; m_age = 0; m_P = eff(period); m_last = 0;
            end
          end
          1: begin
            if (stop) m_state = 0;
            else begin
              m_acc_s |= strings;
              hi = top_fret(frets);
              if (hi > m_acc_f) m_acc_f = hi;
              if (b) begin
                m_mem[m_idx] = NW'(m_acc_s) << (m_acc_f * NS);
                m_idx++; m_len++;
                m_acc_s = '0; m_acc_f = 0;
                if (m_len == DP) begin m_full = 1; m_state = 0; end
              end
              m_age++;
            end
          end
          default: begin
            if (stop) m_state = 0;
            else begin
              if (m_last) begin m_state = 0; m_last = 0; end
              if (b) begin
                m_note = m_mem[m_idx];
                m_valid = 1;
                if (m_idx == m_len - 1) begin
                  if (loop_en) m_idx = 0;
                  else m_last = 1;
                end else m_idx++;
              end
              m_age++;
            end
          end
        endcase
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return beat;
      1: return note_valid;
      default: return state == 2'd0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cond(sel) && n < budget);
    chk("wait_event", 32'(cond(sel)), 32'd1);
  endtask

  logic [NW-1:0] exp_n [3];
  int n;

  initial begin
    exp_n[0] = 30'h3;
    exp_n[1] = 30'h400000;
    exp_n[2] = 30'h200;

    repeat (3) step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_length", 32'(length), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_note_out", 32'(note_out), 32'd0);
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_beat", 32'(beat), 32'd0);
    chk_en = 1'b1;
    resetn = 1'b1;
    step();

    // A: period 4, open string 0
    period = 8'd4; strings = 6'b000001; frets = '0;
    rec_start = 1'b1; step(); rec_start = 1'b0;
    wait_for(0, 20, n); chk("first_beat_delay", 32'(n), 32'd3);
    wait_for(0, 20, n); chk("beat_spacing", 32'(n), 32'd4);
    stop = 1'b1; step(); stop = 1'b0;   // stop on a beat discards that note
    chk("A_state", 32'(state), 32'd0);
    chk("A_length", 32'(length), 32'd1);
    strings = '0;
    play_start = 1'b1; step(); play_start = 1'b0;
    wait_for(1, 20, n); chk("play_latency", 32'(n), 32'd4);
    chk("A_word", 32'(note_out), 32'h1);
    step(); chk("A_end_idle", 32'(state), 32'd0);

    // B: sticky pulse on string 2 with frets 1 and 2 held
    frets = 4'b0011;
    rec_start = 1'b1; step(); rec_start = 1'b0;
    strings = 6'b000100; step(); strings = '0;
    wait_for(0, 20, n); step();
    stop = 1'b1; step(); stop = 1'b0;
    frets = '0;
    chk("B_length", 32'(length), 32'd1);
    play_start = 1'b1; step(); play_start = 1'b0;
    wait_for(1, 20, n); chk("B_word", 32'(note_out), 32'h4000);
    step();

    // C: fill the memory at period 2, highest fret and string
    period = 8'd2; strings = 6'b100000; frets = 4'b1000;
    rec_start = 1'b1; step(); rec_start = 1'b0;
    wait_for(2, 40, n); chk("fill_cycles", 32'(n), 32'd8);
    chk("C_full", 32'(full), 32'd1);
    chk("C_length", 32'(length), 32'd4);
    repeat (6) step();
    chk("C_length_hold", 32'(length), 32'd4);
    strings = '0; frets = '0;

    // D: three distinct notes, single playback
    period = 8'd3; strings = 6'b000011; frets = 4'b0000;
    rec_start = 1'b1; step(); rec_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_for(0, 20, n);
      step();
      if (k == 0) begin strings = 6'b010000; frets = 4'b0100; end
      if (k == 1) begin strings = 6'b001000; frets = 4'b0001; end
    end
    stop = 1'b1; step(); stop = 1'b0;
    strings = '0; frets = '0;
    chk("D_length", 32'(length), 32'd3);
    chk("D_full", 32'(full), 32'd0);
    loop_en = 1'b0;
    play_start = 1'b1; step(); play_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_for(1, 20, n);
      chk("D_play_word", 32'(note_out), 32'(exp_n[k]));
    end
    wait_for(2, 5, n); chk("D_idle_after", 32'(n), 32'd1);

    // E: loop playback then stop
    loop_en = 1'b1;
    play_start = 1'b1; step(); play_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_for(1, 20, n);
      chk("E_loop_word", 32'(note_out), 32'(exp_n[k % 3]));
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("E_stop_state", 32'(state), 32'd0);
    n = 0;
    repeat (10) begin step(); if (note_valid) n++; end
    chk("E_no_valid", 32'(n), 32'd0);
    loop_en = 1'b0;

    // F: empty play, simultaneous commands, period 0, reset in PLAY
    rec_start = 1'b1; step(); rec_start = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    chk("F_empty_len", 32'(length), 32'd0);
    play_start = 1'b1; step(); play_start = 1'b0;
    chk("F_play_empty", 32'(state), 32'd0);
    rec_start = 1'b1; stop = 1'b1; step(); rec_start = 1'b0; stop = 1'b0;
    chk("F_rec_stop", 32'(state), 32'd0);
    period = 8'd0; strings = 6'b000001;
    rec_start = 1'b1; step(); rec_start = 1'b0;
    wait_for(0, 10, n); chk("p0_first_beat", 32'(n), 32'd1);
    wait_for(0, 10, n); chk("p0_spacing", 32'(n), 32'd2);
    stop = 1'b1; step(); stop = 1'b0;
    strings = '0;
    loop_en = 1'b1;
    play_start = 1'b1; step(); play_start = 1'b0;
    wait_for(1, 10, n);
    resetn = 1'b0; step();
    chk("R_state", 32'(state), 32'd0);
    chk("R_length", 32'(length), 32'd0);
    chk("R_full", 32'(full), 32'd0);
    chk("R_note_out", 32'(note_out), 32'd0);
    chk("R_valid", 32'(note_valid), 32'd0);
    chk("R_beat", 32'(beat), 32'd0);
    resetn = 1'b1; loop_en = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
